// File: rtl/seg7_scan_if.sv
// seg7_scan_if: value load handshake between the datapath result registers and the display controller
interface seg7_scan_if #(parameter int VAL_W = 14);
  logic load_valid;
  logic load_ready;
  logic [VAL_W-1:0] value;
  logic blank_lz;
  modport master(output load_valid, value, blank_lz, input load_ready);
  modport slave(input load_valid, value, blank_lz, output load_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: serial binary-to-BCD conversion plus multiplexed digit scanning of a shared 7-segment decoder
module seg7_scan_ctrl #(
  parameter int NDIG = 4,
  parameter int VAL_W = 14,
  parameter int SCAN_DIV = 50000
) (
  input logic clk,
  input logic rst_n,
  seg7_scan_if.slave bus,
  output logic [3:0] digit_code,
  output logic [NDIG-1:0] an_n,
  output logic overflow
);
  localparam int BW = 4 * (NDIG + 1);
  localparam int CW = $clog2(VAL_W + 1);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [VAL_W-1:0] bin;
  logic [BW-1:0] bcd, bcd_adj;
  logic blz, ovf_n, nz;
  logic [3:0] disp [NDIG];
  logic [3:0] disp_n [NDIG];
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic div_tc;
  assign bus.load_ready = state == IDLE;
  assign div_tc = div == DW'(SCAN_DIV - 1);
  assign ovf_n = bcd[4*NDIG +: 4] != 4'd0;
  always_comb begin
    state_n = state == IDLE ? (bus.load_valid ? CONV : IDLE)
            : state == CONV ? (cnt == CW'(VAL_W - 1) ? COMMIT : CONV)
            : IDLE;
  end
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i <= NDIG; i++)
      bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  // walk from the top digit down so nz marks the first significant digit; digit 0 is never blanked
  always_comb begin
    nz = 1'b0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      nz = nz | (bcd[4*i +: 4] != 4'd0);
      disp_n[i] = ovf_n ? 4'hF : (blz && !nz && i != 0) ? 4'hF : bcd[4*i +: 4];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bin <= '0;
      bcd <= '0;
      blz <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < NDIG; i++) disp[i] <= 4'hF;
      div <= '0;
      idx <= '0;
      an_n <= '1;
      digit_code <= 4'hF;
    end else begin
      state <= state_n;
      if (bus.load_valid && bus.load_ready) begin
        bin <= bus.value;
        bcd <= '0;
        blz <= bus.blank_lz;
        cnt <= '0;
      end else if (state == CONV) begin
        {bcd, bin} <= {bcd_adj[BW-2:0], bin, 1'b0};
        cnt <= cnt + CW'(1);
      end
      if (state == COMMIT) begin
        disp <= disp_n;
        overflow <= ovf_n;
      end
      div <= div_tc ? '0 : div + DW'(1);
      if (div_tc) idx <= idx == IW'(NDIG - 1) ? '0 : idx + IW'(1);
      an_n <= ~(NDIG'(1) << idx);
      digit_code <= disp[idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of conversion, blanking, overflow, busy-ignore, scanning and async reset
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] digit_code;
  logic [3:0] an_n;
  logic overflow;
  int errors = 0;
  int checks = 0;
  seg7_scan_if #(.VAL_W(14)) bus();
  seg7_scan_ctrl #(.NDIG(4), .VAL_W(14), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .digit_code(digit_code), .an_n(an_n), .overflow(overflow)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  task automatic do_load(input logic [13:0] v, input logic b);
    @(negedge clk);
    bus.load_valid = 1'b1;
    bus.value = v;
    bus.blank_lz = b;
    @(posedge clk);
    #1 bus.load_valid = 1'b0;
  endtask
  task automatic read_digits(output logic [15:0] d);
    d = 'x;
    repeat (16) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (an_n == ~(4'b0001 << j)) d[4*j +: 4] = digit_code;
    end
  endtask
  task automatic run_load(input logic [13:0] v, input logic b, output logic [15:0] d, output logic o, output logic r);
    do_load(v, b);
    repeat (16) @(negedge clk);
    r = bus.load_ready;
    o = overflow;
    read_digits(d);
  endtask
  task automatic test_reset();
    logic [3:0] exp_an;
    repeat (10) @(negedge clk);
    checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL rst_an_n got=%b exp=1111", an_n); end
    checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL rst_digit_code got=%h exp=f", digit_code); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got=%b exp=1", bus.load_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_an = ~(4'b0001 << (((k - 1) / 4) % 4));
      checks++; if (an_n !== exp_an) begin errors++; $display("FAIL scan_an_n k=%0d got=%b exp=%b", k, an_n, exp_an); end
      checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL scan_blank k=%0d got=%h exp=f", k, digit_code); end
    end
  endtask
  task automatic test_convert();
    logic [15:0] d;
    int busy = 0;
    do_load(14'd1234, 1'b0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.load_ready === 1'b0) busy++;
    end
    checks++; if (busy != 15) begin errors++; $display("FAIL conv_busy_cycles got=%0d exp=15", busy); end
    @(negedge clk);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL conv_ready_back got=%b exp=1", bus.load_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL conv_overflow got=%b exp=0", overflow); end
    read_digits(d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL conv_1234 got=%h exp=1234", d); end
  endtask
  task automatic test_blanking();
    logic [15:0] d;
    logic o, r;
    run_load(14'd7, 1'b1, d, o, r);
    checks++; if (d !== 16'hFFF7) begin errors++; $display("FAIL blank_7 got=%h exp=fff7", d); end
    run_load(14'd7, 1'b0, d, o, r);
    checks++; if (d !== 16'h0007) begin errors++; $display("FAIL noblank_7 got=%h exp=0007", d); end
    run_load(14'd0, 1'b1, d, o, r);
    checks++; if (d !== 16'hFFF0) begin errors++; $display("FAIL blank_0 got=%h exp=fff0", d); end
    run_load(14'd1050, 1'b1, d, o, r);
    checks++; if (d !== 16'h1050) begin errors++; $display("FAIL blank_1050 got=%h exp=1050", d); end
  endtask
  task automatic test_overflow();
    logic [15:0] d;
    logic o, r;
    run_load(14'd12000, 1'b0, d, o, r);
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", o); end
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL ovf_digits got=%h exp=ffff", d); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold got=%b exp=1", overflow); end
    run_load(14'd9999, 1'b0, d, o, r);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", o); end
    checks++; if (d !== 16'h9999) begin errors++; $display("FAIL max_9999 got=%h exp=9999", d); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] d;
    int bad = 0;
    do_load(14'd1234, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      for (int j = 0; j < 4; j++)
        if (an_n == ~(4'b0001 << j) && digit_code !== 4'h9) bad++;
      if (k == 4) begin bus.load_valid = 1'b1; bus.value = 14'd5678; bus.blank_lz = 1'b1; end
      if (k == 5) bus.load_valid = 1'b0;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL conv_old_digits got=%0d_bad exp=0_bad", bad); end
    @(negedge clk);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL busy_ready got=%b exp=1", bus.load_ready); end
    read_digits(d);
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL busy_ignored got=%h exp=1234", d); end
    repeat (20) @(negedge clk);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL busy_no_queue got=%b exp=1", bus.load_ready); end
  endtask
  task automatic test_async_reset();
    logic [15:0] d;
    logic o, r;
    run_load(14'd16383, 1'b0, d, o, r);
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL pre_abort_ovf got=%b exp=1", o); end
    do_load(14'd1234, 1'b0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (an_n !== 4'b1111) begin errors++; $display("FAIL abort_an_n got=%b exp=1111", an_n); end
    checks++; if (digit_code !== 4'hF) begin errors++; $display("FAIL abort_digit_code got=%h exp=f", digit_code); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", bus.load_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_overflow got=%b exp=0", overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (an_n !== 4'b1110) begin errors++; $display("FAIL abort_scan_restart got=%b exp=1110", an_n); end
    repeat (30) @(negedge clk);
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL post_abort_ready got=%b exp=1", bus.load_ready); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL post_abort_overflow got=%b exp=0", overflow); end
    read_digits(d);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL post_abort_blank got=%h exp=ffff", d); end
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.value = '0;
    bus.blank_lz = 1'b0;
    test_reset();
    test_convert();
    test_blanking();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Sequential controller that accepts a binary value through a valid/ready handshake.
- Converts the value to BCD with a serial shift-add-3 (double-dabble) engine.
- Time-multiplexes NDIG digits through one shared seg7_decoder instance by driving its 4-bit digit code and the active-low digit enables.
- Sits between the datapath result registers and the board display.

Parameters:
- NDIG, 4, number of display digits scanned.
- VAL_W, 14, input value width; must satisfy 2^VAL_W-1 < 10^(NDIG+1).
- SCAN_DIV, 50000, clock cycles each digit stays enabled; must be >= 2.

Ports:
- clk  in  1  system clock; the block uses this one clock only.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load_valid  in  1  value presented for display.
- load_ready  out  1  block can accept a value this cycle.
- value  in  VAL_W  unsigned binary value.
- blank_lz  in  1  leading-zero blanking enable; sampled with value.
- digit_code  out  4  code to shared decoder; 4'hF means blank.
- an_n  out  NDIG  digit enables, active-low, one-hot-low while scanning.
- overflow  out  1  last committed value exceeded 10^NDIG-1.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - load_ready=1, digit_code=4'hF, an_n=all ones, overflow=0.
  - All display digit registers = 4'hF.
  - Scan index=0, divider=0, FSM=IDLE.
- Accept: handshake completes when load_valid && load_ready on a rising edge. Value and blank_lz are captured; the FSM goes to CONV.
- FSM states:
  - IDLE: load_ready=1.
  - CONV: load_ready=0. Runs exactly VAL_W cycles. Each cycle:
    - Add 3 to every BCD nibble >= 5 in the (NDIG+1)-digit BCD register.
    - Then shift {bcd, bin} left by 1.
  - COMMIT: one cycle, load_ready=0.
    - Write NDIG display registers from BCD digits 0..NDIG-1, applying blanking.
    - overflow = (BCD digit NDIG != 0).
    - Return to IDLE.
- Latency: accept at edge t, display registers and overflow update at edge t+VAL_W+1. load_ready is high again from the cycle after that edge.
- load_valid while load_ready=0 is ignored; no queueing.
- Overflow commit: all display registers = 4'hF and overflow=1. overflow holds until the next COMMIT.
- Leading-zero blanking (blank_lz=1): digits above the most significant nonzero digit are written as 4'hF. Digit 0 always shows its value, so value 0 displays "0". With blank_lz=0, all digits are shown.
- Double buffering: scanning continues from the old display registers throughout CONV. There is no visible glitch.
- Scanner:
  - Divider counts 0..SCAN_DIV-1 continuously from reset release. At the terminal count the scan index increments, wrapping NDIG-1 -> 0.
  - an_n and digit_code are registered and recomputed every cycle: an_n = ~(1<<idx), digit_code = disp[idx].
  - First edge after reset release gives an_n=...1110 and digit_code=4'hF.
- Reset asserted mid-CONV: conversion aborts, display blanks, scan restarts at digit 0.
- Arithmetic: BCD register is 4*(NDIG+1) bits; the add-3 step is applied per nibble before the shift. Binary shift register is VAL_W bits.

Test Plan:
- Reset, hold 10 cycles, SCAN_DIV=4:
  - During reset: an_n=4'b1111, digit_code=F, load_ready=1, overflow=0.
  - After release: an_n sequence 1110,1101,1011,0111,1110 changing every 4 cycles; digit_code=F throughout.
- Load 1234, blank_lz=0:
  - load_ready=0 for 15 cycles after accept.
  - Commit 15 edges after accept; digit_code per index = 4,3,2,1; overflow=0.
- Load 7, blank_lz=1: digits 0..3 = 7,F,F,F. Same with blank_lz=0: 7,0,0,0. Load 0 with blank_lz=1: 0,F,F,F.
- Load 12000: overflow=1 and all digits F. Then load 9999: overflow=0 and digits 9,9,9,9.
- Load 1234, then pulse load_valid with 5678 during CONV: 5678 ignored, 1234 displayed. Old digits keep scanning unchanged during CONV.
- Assert rst_n low asynchronously at CONV cycle 6: outputs go to reset values immediately without a clock edge. After release, the display stays blank and load_ready=1.
